// File: rtl/cache_rtl_pkg.sv
// Shared MESI, bus and processor encodings for the cache-line controllers.
// Also holds the accept-time resolution helper used by the initiator FSM.
package cache_rtl_pkg;

  typedef enum logic [2:0] {
    MESI_I = 3'b000,
    MESI_E = 3'b001,
    MESI_S = 3'b010,
    MESI_M = 3'b011
  } mesi_e;

  typedef enum logic [1:0] {
    BUS_NO_REQ         = 2'd0,
    BUS_READ_REQ       = 2'd1,
    BUS_INVALIDATE_REQ = 2'd2,
    BUS_RWITM_REQ      = 2'd3
  } bus_req_e;

  typedef enum logic [1:0] {
    BUS_NO_RSP          = 2'd0,
    BUS_SNOOP_FOUND_RSP = 2'd1
  } bus_rsp_e;

  typedef enum logic [1:0] {
    PROC_NO_REQ    = 2'd0,
    PROC_READ_REQ  = 2'd1,
    PROC_WRITE_REQ = 2'd2
  } proc_req_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARB      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } fsm_e;

  typedef struct packed {
    logic     hit;
    bus_req_e op;
    mesi_e    new_st;
  } accept_t;

  // Reserved line-state codes are treated like INVALID (forces a bus access).
  function automatic accept_t resolve_accept(input logic is_wr, input logic [2:0] st);
    accept_t res;
    res.hit    = 1'b0;
    res.op     = BUS_NO_REQ;
    res.new_st = MESI_I;
    if (!is_wr) begin
      if (st == MESI_S || st == MESI_E || st == MESI_M) begin
        res.hit    = 1'b1;
        res.new_st = mesi_e'(st);
      end else begin
        res.op = BUS_READ_REQ;
      end
    end else begin
      if (st == MESI_E || st == MESI_M) begin
        res.hit    = 1'b1;
        res.new_st = MESI_M;
      end else if (st == MESI_S) begin
        res.op = BUS_INVALIDATE_REQ;
      end else begin
        res.op = BUS_RWITM_REQ;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rsp_timeout_cnt.sv
// Cycle counter bounding the wait for a bus snoop response.
module rsp_timeout_cnt #(
  parameter int RSP_TO_CYC = 16,
  parameter int CNT_W      = $clog2(RSP_TO_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_W'(RSP_TO_CYC - 1));
  assign o_expired = w_expired;

  // Saturates at the expiry value so the flag stays stable if the wait is extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_proc_req_ctrl.sv
// Processor-side MESI controller for a single cache-line access: resolves hits
// locally, otherwise arbitrates for the bus and waits for the snoop response.
module fsm_proc_req_ctrl
  import cache_rtl_pkg::*;
#(
  parameter int RSP_TO_CYC = 16,
  parameter int CNT_W      = $clog2(RSP_TO_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_proc_req,
  input  logic [2:0] i_cur_state,
  input  logic       i_snoop_inv,
  input  logic       i_bus_gnt,
  input  logic       i_bus_rsp_vld,
  input  logic [1:0] i_bus_rsp,
  output logic [1:0] o_bus_req,
  output logic       o_busy,
  output logic       o_state_upd,
  output logic [2:0] o_nxt_state,
  output logic       o_proc_rsp_vld,
  output logic       o_proc_rsp_err
);

  fsm_e      r_state;
  fsm_e      w_state_next;
  proc_req_e r_req;
  bus_req_e  r_op;
  mesi_e     r_new;
  logic      r_err;
  logic      r_backoff;
  logic      w_accept;
  logic      w_grant_ok;
  logic      w_expired;
  accept_t   w_res;

  assign w_accept   = (i_proc_req == PROC_READ_REQ) || (i_proc_req == PROC_WRITE_REQ);
  assign w_res      = resolve_accept(i_proc_req == PROC_WRITE_REQ, i_cur_state);
  assign w_grant_ok = !r_backoff && i_bus_gnt && !i_snoop_inv;

  rsp_timeout_cnt #(
    .RSP_TO_CYC (RSP_TO_CYC),
    .CNT_W      (CNT_W)
  ) u_rsp_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state != ST_WAIT_RSP),
    .i_en      (r_state == ST_WAIT_RSP),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_res.hit ? ST_DONE : ST_ARB;
        end
      end
      ST_ARB: begin
        if (w_grant_ok) begin
          w_state_next = (r_op == BUS_INVALIDATE_REQ) ? ST_DONE : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (i_bus_rsp_vld || w_expired) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= PROC_NO_REQ;
      r_op      <= BUS_NO_REQ;
      r_new     <= MESI_I;
      r_err     <= 1'b0;
      r_backoff <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req     <= proc_req_e'(i_proc_req);
            r_op      <= w_res.op;
            r_new     <= w_res.new_st;
            r_err     <= 1'b0;
            r_backoff <= 1'b0;
          end
        end
        ST_ARB: begin
          r_backoff <= 1'b0;
          if (!r_backoff) begin
            // A snoop invalidation racing the grant loses the line: drop the
            // grant for a cycle and refetch with RWITM instead of upgrading.
            if (i_bus_gnt && i_snoop_inv) begin
              r_backoff <= 1'b1;
              if (r_op == BUS_INVALIDATE_REQ) begin
                r_op <= BUS_RWITM_REQ;
              end
            end else if (i_bus_gnt) begin
              if (r_op == BUS_INVALIDATE_REQ) begin
                r_new <= MESI_M;
              end
            end else if (i_snoop_inv && (r_op == BUS_INVALIDATE_REQ)) begin
              r_op <= BUS_RWITM_REQ;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (i_bus_rsp_vld) begin
            if (r_req == PROC_READ_REQ) begin
              r_new <= (i_bus_rsp == BUS_SNOOP_FOUND_RSP) ? MESI_S : MESI_E;
            end else begin
              r_new <= MESI_M;
            end
            r_err <= 1'b0;
          end else if (w_expired) begin
            r_new <= MESI_I;
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_bus_req      = BUS_NO_REQ;
    o_busy         = (r_state != ST_IDLE);
    o_state_upd    = 1'b0;
    o_nxt_state    = MESI_I;
    o_proc_rsp_vld = 1'b0;
    o_proc_rsp_err = 1'b0;
    if ((r_state == ST_ARB) && !r_backoff) begin
      o_bus_req = r_op;
    end
    if (r_state == ST_DONE) begin
      o_state_upd    = 1'b1;
      o_nxt_state    = r_new;
      o_proc_rsp_vld = 1'b1;
      o_proc_rsp_err = r_err;
    end
  end

endmodule

// File: doc/fsm_proc_req_ctrl.md
Name: fsm_proc_req_ctrl

Overview:
Processor-side (initiator) MESI controller for one cache line access. It accepts a processor read or write, decides locally on a hit, and otherwise issues BUS_READ_REQ, BUS_RWITM_REQ or BUS_INVALIDATE_REQ. It waits for arbitration and the snoop response, then produces the line's next MESI state. It is the counterpart of the snoop-side controller, which consumes these bus requests and drives BUS_SNOOP_FOUND_RSP.

Parameters:
RSP_TO_CYC, 16, maximum cycles spent in WAIT_RSP before timeout (at least 2)
CNT_W, $clog2(RSP_TO_CYC+1), timeout counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
proc_req  in  2  PROC_NO_REQ=0, PROC_READ_REQ=1, PROC_WRITE_REQ=2 (3 reserved, treated as NO_REQ)
cur_state  in  3  MESI state of the addressed line, sampled on accept
snoop_inv  in  1  snoop controller is invalidating this line this cycle
bus_gnt  in  1  bus arbiter grant
bus_rsp_vld  in  1  bus_rsp valid
bus_rsp  in  2  BUS_NO_RSP=0, BUS_SNOOP_FOUND_RSP=1
bus_req  out  2  BUS_NO_REQ=0, BUS_READ_REQ=1, BUS_INVALIDATE_REQ=2, BUS_RWITM_REQ=3
busy  out  1  high in every FSM state except IDLE
state_upd  out  1  one-cycle strobe: write nxt_state into the tag array
nxt_state  out  3  new MESI state, valid only while state_upd=1
proc_rsp_vld  out  1  one-cycle completion strobe to the processor
proc_rsp_err  out  1  completion with timeout, qualified by proc_rsp_vld

Behaviour:
- MESI encoding: INVALID=3'b000, EXCLUSIVE=3'b001, SHARED=3'b010, MODIFIED=3'b011.
- Reset: all outputs are 0 and the FSM is in IDLE. Reset takes effect immediately, even mid-transaction; the in-flight request is dropped and no response is given.
- FSM states:
  - IDLE: accept when proc_req != NO_REQ. Register the request (req_q) and cur_state (st_q). Ignore proc_req in all other states; the requester holds proc_req until it sees busy=0.
  - Hit resolution on accept, going to DONE next cycle:
    - READ with st in {S, E, M}: new state = st.
    - WRITE with st in {E, M}: new state = MODIFIED (silent E->M upgrade).
  - Bus resolution on accept, going to ARB:
    - READ with INVALID: op=READ.
    - WRITE with INVALID: op=RWITM.
    - WRITE with SHARED: op=INVALIDATE.
  - ARB: bus_req=op, held stable until the cycle bus_gnt=1 (inclusive).
    - On grant: INVALIDATE goes to DONE with new state MODIFIED; READ and RWITM go to WAIT_RSP with the counter cleared.
    - If snoop_inv=1 while op=INVALIDATE and no grant in the same cycle, op becomes RWITM from the next cycle. The line was lost, so data must be refetched.
    - If snoop_inv=1 in the same cycle as the grant, the grant is abandoned. bus_req returns to NO for one cycle, then ARB re-arbitrates with op=RWITM.
  - WAIT_RSP: bus_req=NO and the counter increments each cycle.
    - When bus_rsp_vld=1: READ gives SHARED if bus_rsp=SNOOP_FOUND, otherwise EXCLUSIVE. RWITM always gives MODIFIED. Then go to DONE.
    - If the counter reaches RSP_TO_CYC-1 without a valid response: go to DONE with new state INVALID and err=1.
    - If bus_rsp_vld and the timeout coincide, the response wins and no error is raised.
  - DONE: for one cycle, state_upd=1, proc_rsp_vld=1, nxt_state=new state, proc_rsp_err=err. Then go to IDLE; busy drops the same cycle DONE exits.
- Latency:
  - Hit: accept in cycle 0, proc_rsp_vld in cycle 1.
  - Upgrade: grant cycle + 1.
  - Miss: bus_rsp_vld cycle + 1.
  - A new request can be accepted in the cycle after DONE.
- All outputs are registered or decoded from the FSM state only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package cache_rtl_pkg:
  - MESI state enum.
  - Bus request and bus response enums.
  - Processor request enum.
  - FSM state enum (IDLE, ARB, WAIT_RSP, DONE).
- The same encodings are used by the snoop-side controller.
- One sub-module, rsp_timeout_cnt: clear, enable, and an expired flag at RSP_TO_CYC-1.

Test Plan:
- Read hit: proc_req=READ, cur_state=EXCLUSIVE -> bus_req stays 0; cycle 1 gives state_upd=1, nxt_state=3'b001, proc_rsp_vld=1.
- Read miss with sharer: proc_req=READ, cur_state=INVALID -> bus_req=1 until bus_gnt (grant at cycle 3); bus_rsp_vld with bus_rsp=1 at cycle 6 -> cycle 7 gives nxt_state=SHARED (3'b010). Repeat with bus_rsp=0 -> nxt_state=EXCLUSIVE.
- Write to SHARED: bus_req=2, grant at cycle 2 -> cycle 3 gives nxt_state=MODIFIED, no WAIT_RSP.
- Snoop steals during upgrade: write to SHARED, snoop_inv=1 at cycle 1 with no grant -> bus_req becomes 3 from cycle 2; grant, then response -> nxt_state=MODIFIED.
- Timeout with RSP_TO_CYC=4: RWITM granted, no bus_rsp_vld -> DONE after 4 WAIT_RSP cycles with proc_rsp_err=1, nxt_state=INVALID. A second run has bus_rsp_vld exactly at the expiry cycle -> err=0.
- Reset mid-op: rst_n low during WAIT_RSP -> all outputs 0 immediately; after release, busy=0 and a new READ hit completes in 1 cycle.
